// File: rtl/fp_command_sequencer_pkg.sv
// Shared types for the front-panel command sequencer: FSM states, command
// bit positions in the pending vector, and the priority pick helper.
package fp_command_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_MEM_WAIT  = 3'd2,
    ST_PC_INC    = 3'd3,
    ST_STEP_WAIT = 3'd4
  } state_e;

  localparam int unsigned NUM_CMDS    = 5;
  localparam int unsigned CMD_LOADPC  = 0;
  localparam int unsigned CMD_LOADAC  = 1;
  localparam int unsigned CMD_DEPOSIT = 2;
  localparam int unsigned CMD_EXAMINE = 3;
  localparam int unsigned CMD_STEP    = 4;

  typedef logic [NUM_CMDS-1:0] cmd_vec_t;

  // Lowest index wins, which gives loadpc > loadac > deposit > examine > step.
  function automatic cmd_vec_t lowest_set(input cmd_vec_t v);
    return v & (~v + cmd_vec_t'(1));
  endfunction

endpackage

// File: rtl/fp_command_sequencer_req_pending.sv
// Pending-request register and fixed-priority grant for the panel commands.
module fp_req_pending
  import fp_command_sequencer_pkg::*;
(
  input  logic     clock,
  input  logic     resetN,
  input  cmd_vec_t req_i,
  input  logic     run_i,
  input  logic     grant_en_i,
  output cmd_vec_t pending_o,
  output logic     grant_o,
  output cmd_vec_t grant_vec_o
);

  cmd_vec_t pend_q, pend_d;

  always_comb begin
    grant_o     = 1'b0;
    grant_vec_o = '0;
    pend_d      = pend_q;
    if (grant_en_i && !run_i && (pend_q != '0)) begin
      grant_o     = 1'b1;
      grant_vec_o = lowest_set(pend_q);
    end
    // A new pulse re-arms its bit even in the cycle that bit is granted.
    if (run_i) pend_d = '0;
    else       pend_d = (pend_q & ~grant_vec_o) | req_i;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/fp_command_sequencer.sv
// PDP-8 front-panel command sequencer: turns panel pulses into PC/AC loads,
// memory deposit/examine cycles with PC auto-increment, and single steps.
module fp_command_sequencer
  import fp_command_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned W              = 12
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic         loadpc_req_i,
  input  logic         loadac_req_i,
  input  logic         deposit_req_i,
  input  logic         examine_req_i,
  input  logic         step_req_i,
  input  logic [W-1:0] swreg_i,
  input  logic         run_i,
  input  logic         cpu_idle_i,
  input  logic [W-1:0] pc_in_i,
  output logic         pc_load_o,
  output logic [W-1:0] pc_value_o,
  output logic         ac_load_o,
  output logic [W-1:0] ac_value_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [W-1:0] mem_addr_o,
  output logic [W-1:0] mem_wdata_o,
  input  logic         mem_ack_i,
  input  logic [W-1:0] mem_rdata_i,
  output logic         step_go_o,
  input  logic         step_done_i,
  output logic [W-1:0] mb_reg_o,
  output logic         busy_o,
  output logic         error_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e         state_q, state_d;
  cmd_vec_t       cmd_q, cmd_d;
  logic [W-1:0]   addr_q, addr_d;
  logic [W-1:0]   data_q, data_d;
  logic [W-1:0]   mb_q, mb_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  cmd_vec_t       req_vec, pending, grant_vec;
  logic           grant;
  logic           grant_en;

  assign req_vec  = {step_req_i, examine_req_i, deposit_req_i, loadac_req_i, loadpc_req_i};
  assign grant_en = (state_q == ST_IDLE) && cpu_idle_i;

  fp_req_pending u_pending (
    .clock       (clock),
    .resetN      (resetN),
    .req_i       (req_vec),
    .run_i       (run_i),
    .grant_en_i  (grant_en),
    .pending_o   (pending),
    .grant_o     (grant),
    .grant_vec_o (grant_vec)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mb_d        = mb_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    pc_load_o   = 1'b0;
    pc_value_o  = '0;
    ac_load_o   = 1'b0;
    ac_value_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    step_go_o   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          cmd_d  = grant_vec;
          addr_d = pc_in_i;
          data_d = swreg_i;
          cnt_d  = '0;
          err_d  = 1'b0;
          if (grant_vec[CMD_LOADPC] || grant_vec[CMD_LOADAC])       state_d = ST_LOAD;
          else if (grant_vec[CMD_DEPOSIT] || grant_vec[CMD_EXAMINE]) state_d = ST_MEM_WAIT;
          else                                                       state_d = ST_STEP_WAIT;
        end
      end
      ST_LOAD: begin
        pc_load_o  = cmd_q[CMD_LOADPC];
        pc_value_o = cmd_q[CMD_LOADPC] ? data_q : '0;
        ac_load_o  = cmd_q[CMD_LOADAC];
        ac_value_o = cmd_q[CMD_LOADAC] ? data_q : '0;
        state_d    = ST_IDLE;
      end
      ST_MEM_WAIT: begin
        // Address/data come from grant-time captures, so they hold steady.
        mem_req_o   = 1'b1;
        mem_we_o    = cmd_q[CMD_DEPOSIT];
        mem_addr_o  = addr_q;
        mem_wdata_o = cmd_q[CMD_DEPOSIT] ? data_q : '0;
        if (mem_ack_i) begin
          mb_d    = cmd_q[CMD_DEPOSIT] ? data_q : mem_rdata_i;
          state_d = ST_PC_INC;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PC_INC: begin
        pc_load_o  = 1'b1;
        pc_value_o = addr_q + W'(1);
        state_d    = ST_IDLE;
      end
      ST_STEP_WAIT: begin
        step_go_o = (cnt_q == '0);
        if (step_done_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mb_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mb_q    <= mb_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mb_reg_o = mb_q;
  assign error_o  = err_q;
  assign busy_o   = (state_q != ST_IDLE) || (pending != '0);

endmodule

// File: doc/fp_command_sequencer.md
FP_COMMAND_SEQUENCER -- requirements
Module: fp_command_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning maximum cycles to wait for mem_ack or step_done.
REQ-002 SHALL have parameter W, default 12, meaning PDP-8 word/address width.
REQ-003 clock  in  1  system clock; all state updates on rising edge.
REQ-004 resetN  in  1  reset, asynchronous, active-low.
REQ-005 loadpc_req, loadac_req, deposit_req, examine_req, step_req  in  1 each  one-cycle debounced panel pulses.
REQ-006 swreg  in  W  switch register value.
REQ-007 run  in  1  CPU running; cpu_idle  in  1  CPU at instruction boundary.
REQ-008 pc_in  in  W  current PC.
REQ-009 pc_load  out  1  one-cycle PC write strobe; pc_value  out  W  PC write data.
REQ-010 ac_load  out  1  one-cycle AC write strobe; ac_value  out  W  AC write data.
REQ-011 mem_req  out  1  memory request, held until mem_ack; mem_we  out  1  write enable; mem_addr, mem_wdata  out  W.
REQ-012 mem_ack  in  1  one-cycle completion; mem_rdata  in  W  read data, valid with mem_ack.
REQ-013 step_go  out  1  one-cycle single-instruction start; step_done  in  1  instruction complete pulse.
REQ-014 mb_reg  out  W  last deposited/examined word; busy  out  1  state not IDLE or any pending bit set; error  out  1  sticky timeout flag.

Function
REQ-015 SHALL keep a 5-bit pending register; a request pulse sets its bit when run=0, and is dropped when run=1.
REQ-016 SHALL clear all pending bits in any cycle run=1.
REQ-017 SHALL grant in state IDLE only when run=0, cpu_idle=1 and any bit is pending, with fixed priority loadpc > loadac > deposit > examine > step; the granted bit clears in the grant cycle.
REQ-018 SHALL have states IDLE, LOAD, MEM_WAIT, PC_INC, STEP_WAIT.
REQ-019 loadpc: IDLE->LOAD; in LOAD assert pc_load=1, pc_value=swreg for one cycle, then IDLE.
REQ-020 loadac: IDLE->LOAD; in LOAD assert ac_load=1, ac_value=swreg for one cycle, then IDLE.
REQ-021 deposit: IDLE->MEM_WAIT with mem_req=1, mem_we=1, mem_addr=pc_in, mem_wdata=swreg captured at grant; on mem_ack, mb_reg<=swreg value captured, ->PC_INC.
REQ-022 examine: IDLE->MEM_WAIT with mem_req=1, mem_we=0, mem_addr=pc_in captured at grant; on mem_ack, mb_reg<=mem_rdata, ->PC_INC.
REQ-023 PC_INC SHALL assert pc_load=1, pc_value=(captured address+1) mod 2^W (7777 octal wraps to 0000) for one cycle, then IDLE.
REQ-024 step: IDLE->STEP_WAIT, step_go=1 in first STEP_WAIT cycle only; on step_done ->IDLE.
REQ-025 mem_addr/mem_wdata/mem_we SHALL stay stable while mem_req=1.
REQ-026 SHALL count cycles in MEM_WAIT and STEP_WAIT; when count reaches TIMEOUT_CYCLES without ack/done, drop mem_req, set error=1, go IDLE, no PC update.
REQ-027 error SHALL clear on the next granted command.
REQ-028 Request pulse arriving in its own already-pending bit SHALL be merged (no double execution).
REQ-029 Request for a bit in the same cycle it is granted SHALL set it pending again.
REQ-030 Strobes pc_load, ac_load, step_go SHALL never be asserted together; all are 0 in IDLE.

Reset
REQ-031 resetN low SHALL force state IDLE, pending=0, counter=0, error=0, mb_reg=0, all strobes and mem_req 0, value/address outputs 0, immediately and regardless of clock.
REQ-032 Reset mid-transaction SHALL abandon it without PC update; mem_ack after reset SHALL be ignored.

Structure
REQ-033 State enum and command index constants SHALL live in CPU_Definitions.pkg.
REQ-034 Pending register plus priority encoder SHALL be one sub-module, fp_req_pending.

Verification
REQ-035 pc_in=0200, swreg=1234, deposit_req -> write 1234 to 0200, mb_reg=1234, pc_load with 0201.
REQ-036 pc_in=7777, examine_req, mem_rdata=4321 -> read at 7777, mb_reg=4321, pc_value=0000.
REQ-037 loadpc_req and step_req same cycle -> pc_load first, then step_go; exactly one of each.
REQ-038 run=1, loadac_req pulse -> no ac_load, busy=0 after run falls.
REQ-039 deposit with mem_ack withheld, TIMEOUT_CYCLES=8 -> mem_req drops after 8 cycles, error=1, no pc_load; next loadpc clears error.
REQ-040 resetN low during MEM_WAIT -> mem_req=0 immediately, later mem_ack produces no pc_load.
